// File: rtl/xcorr_tdoa_estimator.sv
// ---------------------------------------------------------------------------
// xcorr_tdoa_estimator
//
// Estimates the time difference of arrival between two mic sample streams.
// Each counted sample pair adds one product per lag into NLAG accumulators
// using a single time-shared MAC. After WINDOW counted samples, an argmax
// scan picks the best lag.
//
// Lag convention: lag k pairs a[n-MAX_LAG] with b[n-MAX_LAG+k]. A positive
// lag therefore means b lags a. On ties the most negative lag wins.
//
// Ports:
//   clk_in           audio clock
//   rst_in           synchronous, active-high reset
//   sample_valid_in  one-cycle pulse qualifying mic_a_in / mic_b_in
//   mic_a_in         signed 16-bit reference mic sample
//   mic_b_in         signed 16-bit second mic sample
//   start_in         one-cycle pulse that begins an estimate (only in IDLE)
//   busy_out         high from an accepted start until done_out
//   done_out         one-cycle pulse when lag_out / peak_out update
//   lag_out          signed best lag in samples
//   peak_out         signed correlation value at lag_out
//   overrun_out      sticky; a sample arrived during MAC and was dropped
//
// Optional build macro: XCORR_SIGN_EN. When defined, each product becomes
// a sign correlation (+1 if the sign bits match, -1 otherwise).
//
// Handshake: sample_valid_in and start_in are single-cycle strobes with no
// back-pressure. A sample that arrives while the MAC sweep is running is
// lost, and overrun_out records the loss.
// ---------------------------------------------------------------------------
module xcorr_tdoa_estimator #(
    parameter int MAX_LAG = 16,
    parameter int WINDOW  = 1024,
    parameter int ACC_W   = 48,
    parameter int LAG_W   = $clog2(MAX_LAG + 1) + 1
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    sample_valid_in,
    input  logic signed [15:0]      mic_a_in,
    input  logic signed [15:0]      mic_b_in,
    input  logic                    start_in,
    output logic                    busy_out,
    output logic                    done_out,
    output logic signed [LAG_W-1:0] lag_out,
    output logic signed [ACC_W-1:0] peak_out,
    output logic                    overrun_out
);

    localparam int NLAG  = 2 * MAX_LAG + 1;
    localparam int IDX_W = $clog2(NLAG);
    localparam int CNT_W = $clog2(WINDOW + 1);
    localparam int PRM_W = $clog2(NLAG + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NLAG - 1);
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);
    localparam logic [PRM_W-1:0] PRM_FULL = PRM_W'(NLAG);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_MAC,
        S_SCAN,
        S_DONE
    } state_t;

    state_t                  state_q;
    logic signed [15:0]      ha_q   [MAX_LAG+1];  // ha_q[j] = a[n-j]
    logic signed [15:0]      hb_q   [NLAG];       // hb_q[j] = b[n-j]
    logic signed [ACC_W-1:0] acc_q  [NLAG];       // acc_q[i] holds lag i-MAX_LAG
    logic [IDX_W-1:0]        idx_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [PRM_W-1:0]        prime_q;
    logic signed [ACC_W-1:0] best_q;
    logic [IDX_W-1:0]        best_idx_q;
    logic                    busy_q;
    logic                    done_q;
    logic signed [LAG_W-1:0] lag_q;
    logic signed [ACC_W-1:0] peak_q;
    logic                    overrun_q;

    logic                    hist_we;
    logic signed [ACC_W-1:0] prod_d;

    // The history must stay frozen while the MAC sweep reads it.
    assign hist_we = sample_valid_in && (state_q != S_MAC);

    // Lag k = idx_q - MAX_LAG reads b[n-MAX_LAG+k], which is hb_q[2*MAX_LAG-idx_q].
`ifdef XCORR_SIGN_EN
    logic a_neg;
    logic b_neg;
    always_comb begin
        a_neg  = ha_q[MAX_LAG][15];
        b_neg  = hb_q[LAST_IDX - idx_q][15];
        prod_d = (a_neg == b_neg) ? ACC_W'(1) : {ACC_W{1'b1}};
    end
`else
    logic signed [31:0] mul_d;
    always_comb begin
        mul_d  = ha_q[MAX_LAG] * hb_q[LAST_IDX - idx_q];
        prod_d = {{(ACC_W-32){mul_d[31]}}, mul_d};
    end
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= S_IDLE;
            for (int i = 0; i <= MAX_LAG; i++) ha_q[i] <= '0;
            for (int i = 0; i < NLAG; i++) begin
                hb_q[i]  <= '0;
                acc_q[i] <= '0;
            end
            idx_q      <= '0;
            cnt_q      <= '0;
            prime_q    <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            lag_q      <= '0;
            peak_q     <= '0;
            overrun_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (hist_we) begin
                ha_q[0] <= mic_a_in;
                hb_q[0] <= mic_b_in;
                for (int i = 1; i <= MAX_LAG; i++) ha_q[i] <= ha_q[i-1];
                for (int i = 1; i < NLAG; i++) hb_q[i] <= hb_q[i-1];
                if (prime_q != PRM_FULL) prime_q <= prime_q + PRM_W'(1);
            end

            if (sample_valid_in && (state_q == S_MAC)) overrun_q <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (start_in) begin
                        for (int i = 0; i < NLAG; i++) acc_q[i] <= '0;
                        cnt_q     <= '0;
                        overrun_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Primed is judged before this sample's own write, so the
                    // first NLAG samples after reset only fill the history.
                    if (sample_valid_in && (prime_q == PRM_FULL)) begin
                        idx_q   <= '0;
                        state_q <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc_q[idx_q] <= acc_q[idx_q] + prod_d;
                    if (idx_q == LAST_IDX) begin
                        idx_q   <= '0;
                        cnt_q   <= cnt_q + CNT_W'(1);
                        state_q <= (cnt_q == WIN_LAST) ? S_SCAN : S_WAIT;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                S_SCAN: begin
                    // Strict greater-than keeps the earliest (most negative) lag on ties.
                    if ((idx_q == '0) || (acc_q[idx_q] > best_q)) begin
                        best_q     <= acc_q[idx_q];
                        best_idx_q <= idx_q;
                    end
                    if (idx_q == LAST_IDX) begin
                        idx_q   <= '0;
                        state_q <= S_DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    lag_q   <= LAG_W'(best_idx_q) - LAG_W'(MAX_LAG);
                    peak_q  <= best_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_out    = busy_q;
    assign done_out    = done_q;
    assign lag_out     = lag_q;
    assign peak_out    = peak_q;
    assign overrun_out = overrun_q;

endmodule

// File: tb/tb_xcorr_tdoa_estimator.sv
// ---------------------------------------------------------------------------
// tb_xcorr_tdoa_estimator
//
// Self-checking bench for xcorr_tdoa_estimator. The window is shortened to
// keep run time small. The reference model keeps the full list of samples
// written to history. It computes each lag's correlation directly from the
// cross-correlation sum, and decides which samples are dropped or counted
// from the timing rules.
// ---------------------------------------------------------------------------
module tb_xcorr_tdoa_estimator;

    localparam int M   = 16;
    localparam int NL  = 2 * M + 1;
    localparam int WIN = 128;
    localparam int AW  = 48;
    localparam int LW  = $clog2(M + 1) + 1;

    // clock / reset / DUT
    logic                 clk_in = 1'b0;
    logic                 rst_in;
    logic                 sample_valid_in;
    logic signed [15:0]   mic_a_in;
    logic signed [15:0]   mic_b_in;
    logic                 start_in;
    logic                 busy_out;
    logic                 done_out;
    logic signed [LW-1:0] lag_out;
    logic signed [AW-1:0] peak_out;
    logic                 overrun_out;

    always #5 clk_in = ~clk_in;

    xcorr_tdoa_estimator #(.MAX_LAG(M), .WINDOW(WIN), .ACC_W(AW)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .sample_valid_in (sample_valid_in),
        .mic_a_in        (mic_a_in),
        .mic_b_in        (mic_b_in),
        .start_in        (start_in),
        .busy_out        (busy_out),
        .done_out        (done_out),
        .lag_out         (lag_out),
        .peak_out        (peak_out),
        .overrun_out     (overrun_out)
    );

    int checks   = 0;
    int fails    = 0;
    int cyc      = 0;
    int done_cnt = 0;

    always @(negedge clk_in) if (done_out === 1'b1) done_cnt++;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    // reference model
    int     wa[$];
    int     wb[$];
    longint m_acc [NL];
    bit     m_busy;
    bit     m_over;
    int     m_ts;
    int     m_cnt;
    longint m_mac_end;

    function automatic longint prod(int a, int b);
`ifdef XCORR_SIGN_EN
        return ((a < 0) == (b < 0)) ? 64'sd1 : -64'sd1;
`else
        return longint'(a) * longint'(b);
`endif
    endfunction

    task automatic model_reset();
        wa.delete();
        wb.delete();
        m_busy    = 1'b0;
        m_over    = 1'b0;
        m_cnt     = 0;
        m_ts      = 0;
        m_mac_end = -1;
    endtask

    task automatic model_start(int t);
        if (!m_busy) begin
            m_busy = 1'b1;
            m_ts   = t;
            m_cnt  = 0;
            m_over = 1'b0;
            for (int i = 0; i < NL; i++) m_acc[i] = 0;
        end
    endtask

    task automatic model_sample(int t, int a, int b);
        bit counted;
        int n;
        if (t <= m_mac_end) begin
            m_over = 1'b1;
        end else begin
            counted = m_busy && (t > m_ts) && (m_cnt < WIN) && (wa.size() >= NL);
            wa.push_back(a);
            wb.push_back(b);
            if (counted) begin
                n = wa.size() - 1;
                for (int k = -M; k <= M; k++)
                    m_acc[k+M] += prod(wa[n-M], wb[n-M+k]);
                m_cnt++;
                m_mac_end = t + NL;
            end
        end
    endtask

    task automatic model_best(output int lag, output longint pk);
        pk  = m_acc[0];
        lag = -M;
        for (int i = 1; i < NL; i++)
            if (m_acc[i] > pk) begin
                pk  = m_acc[i];
                lag = i - M;
            end
    endtask

    // driver tasks: inputs change #1 after a rising edge and are sampled
    // at the next rising edge, cycle number cyc+1
    task automatic tick();
        @(posedge clk_in);
        cyc++;
        #1;
    endtask

    task automatic pulse_start();
        start_in = 1'b1;
        model_start(cyc + 1);
        tick();
        start_in = 1'b0;
    endtask

    task automatic drive_sample(int a, int b, bit with_start, int gap);
        if (with_start) begin
            start_in = 1'b1;
            model_start(cyc + 1);
        end
        sample_valid_in = 1'b1;
        mic_a_in        = 16'(a);
        mic_b_in        = 16'(b);
        model_sample(cyc + 1, a, b);
        tick();
        sample_valid_in = 1'b0;
        start_in        = 1'b0;
        repeat (gap - 1) tick();
    endtask

    task automatic wait_done(int base, int budget);
        for (int i = 0; i < budget && done_cnt == base; i++) tick();
        m_busy = 1'b0;
    endtask

    function automatic int rnd_sample();
        return int'($urandom_range(0, 20000)) - 10000;
    endfunction

    // scenarios
    task automatic test_reset();
        rst_in = 1'b1; sample_valid_in = 1'b0; start_in = 1'b0;
        mic_a_in = '0; mic_b_in = '0;
        model_reset();
        repeat (3) tick();
        checks++; if (busy_out !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy_out); end
        checks++; if (done_out !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done_out); end
        checks++; if (lag_out !== '0) begin fails++; $display("FAIL reset_lag: got %0d expected 0", lag_out); end
        checks++; if (peak_out !== '0) begin fails++; $display("FAIL reset_peak: got %0d expected 0", peak_out); end
        checks++; if (overrun_out !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b expected 0", overrun_out); end
        rst_in = 1'b0;
        tick();
    endtask

    task automatic test_impulse();
        int base = done_cnt;
        int el;
        longint ep;
        pulse_start();
        for (int s = 0; s < NL + WIN + 2; s++)
            drive_sample((s == 100) ? 16000 : 0, (s == 103) ? 16000 : 0, 1'b0, 36);
        wait_done(base, 200);
        model_best(el, ep);
        checks++; if (done_cnt - base !== 1) begin fails++; $display("FAIL impulse_done_count: got %0d expected 1", done_cnt - base); end
        checks++; if (lag_out !== LW'(el)) begin fails++; $display("FAIL impulse_lag_model: got %0d expected %0d", lag_out, el); end
        checks++; if (peak_out !== AW'(ep)) begin fails++; $display("FAIL impulse_peak_model: got %0d expected %0d", peak_out, ep); end
`ifndef XCORR_SIGN_EN
        checks++; if (lag_out !== LW'(3)) begin fails++; $display("FAIL impulse_lag: got %0d expected 3", lag_out); end
        checks++; if (peak_out !== AW'(256000000)) begin fails++; $display("FAIL impulse_peak: got %0d expected 256000000", peak_out); end
`endif
        checks++; if (overrun_out !== 1'b0) begin fails++; $display("FAIL impulse_overrun: got %b expected 0", overrun_out); end
        checks++; if (busy_out !== 1'b0) begin fails++; $display("FAIL impulse_busy: got %b expected 0", busy_out); end
    endtask

    // b leads a by 5; start arrives together with the first sample, and a
    // second start mid-estimate must be ignored
    task automatic test_lead();
        int base = done_cnt;
        int x[$];
        int el;
        longint ep;
        for (int i = 0; i < WIN + 10; i++) x.push_back(rnd_sample());
        drive_sample(x[0], x[5], 1'b1, 36);
        for (int s = 1; s < WIN + 3; s++) begin
            drive_sample(x[s], x[s+5], 1'b0, 36);
            if (s == 40) pulse_start();
        end
        wait_done(base, 200);
        model_best(el, ep);
        checks++; if (done_cnt - base !== 1) begin fails++; $display("FAIL lead_done_count: got %0d expected 1", done_cnt - base); end
        checks++; if (lag_out !== LW'(el)) begin fails++; $display("FAIL lead_lag_model: got %0d expected %0d", lag_out, el); end
        checks++; if (peak_out !== AW'(ep)) begin fails++; $display("FAIL lead_peak_model: got %0d expected %0d", peak_out, ep); end
`ifndef XCORR_SIGN_EN
        checks++; if (lag_out !== LW'(-5)) begin fails++; $display("FAIL lead_lag: got %0d expected -5", lag_out); end
`endif
        checks++; if (overrun_out !== 1'b0) begin fails++; $display("FAIL lead_overrun: got %b expected 0", overrun_out); end
    endtask

    // samples every 20 cycles: every other one falls inside a MAC sweep
    task automatic test_overrun();
        int base = done_cnt;
        int x[$];
        int el;
        longint ep;
        for (int i = 0; i < 2; i++) x.push_back(0);
        pulse_start();
        for (int s = 0; s < 2 * WIN + 20; s++) begin
            x.push_back(rnd_sample());
            drive_sample(x[s+2], x[s], 1'b0, 20);
        end
        wait_done(base, 200);
        model_best(el, ep);
        checks++; if (done_cnt - base !== 1) begin fails++; $display("FAIL overrun_done_count: got %0d expected 1", done_cnt - base); end
        checks++; if (overrun_out !== 1'b1) begin fails++; $display("FAIL overrun_flag: got %b expected 1", overrun_out); end
        checks++; if (overrun_out !== m_over) begin fails++; $display("FAIL overrun_model: got %b expected %b", overrun_out, m_over); end
        checks++; if (lag_out !== LW'(el)) begin fails++; $display("FAIL overrun_lag_model: got %0d expected %0d", lag_out, el); end
        checks++; if (peak_out !== AW'(ep)) begin fails++; $display("FAIL overrun_peak_model: got %0d expected %0d", peak_out, ep); end
    endtask

    task automatic test_zero_tie();
        int base;
        int el;
        longint ep;
        for (int s = 0; s < 40; s++) drive_sample(0, 0, 1'b0, 36);
        base = done_cnt;
        pulse_start();
        for (int s = 0; s < WIN + 3; s++) drive_sample(0, 0, 1'b0, 36);
        wait_done(base, 200);
        model_best(el, ep);
        checks++; if (done_cnt - base !== 1) begin fails++; $display("FAIL zero_done_count: got %0d expected 1", done_cnt - base); end
        checks++; if (lag_out !== LW'(-M)) begin fails++; $display("FAIL zero_lag_tie: got %0d expected %0d", lag_out, -M); end
        checks++; if (lag_out !== LW'(el)) begin fails++; $display("FAIL zero_lag_model: got %0d expected %0d", lag_out, el); end
        checks++; if (peak_out !== AW'(ep)) begin fails++; $display("FAIL zero_peak_model: got %0d expected %0d", peak_out, ep); end
`ifndef XCORR_SIGN_EN
        checks++; if (peak_out !== '0) begin fails++; $display("FAIL zero_peak: got %0d expected 0", peak_out); end
`endif
        checks++; if (overrun_out !== 1'b0) begin fails++; $display("FAIL zero_overrun_cleared: got %b expected 0", overrun_out); end
    endtask

    task automatic test_reset_restart();
        int base = done_cnt;
        int el;
        longint ep;
        pulse_start();
        for (int s = 0; s < 60; s++) drive_sample(rnd_sample(), rnd_sample(), 1'b0, 36);
        drive_sample(rnd_sample(), rnd_sample(), 1'b0, 5);
        rst_in = 1'b1;
        tick();
        model_reset();
        checks++; if (busy_out !== 1'b0) begin fails++; $display("FAIL midreset_busy: got %b expected 0", busy_out); end
        checks++; if (done_out !== 1'b0) begin fails++; $display("FAIL midreset_done: got %b expected 0", done_out); end
        checks++; if (lag_out !== '0) begin fails++; $display("FAIL midreset_lag: got %0d expected 0", lag_out); end
        checks++; if (peak_out !== '0) begin fails++; $display("FAIL midreset_peak: got %0d expected 0", peak_out); end
        checks++; if (overrun_out !== 1'b0) begin fails++; $display("FAIL midreset_overrun: got %b expected 0", overrun_out); end
        rst_in = 1'b0;
        repeat (100) tick();
        checks++; if (done_cnt !== base) begin fails++; $display("FAIL midreset_no_done: got %0d pulses expected 0", done_cnt - base); end
        pulse_start();
        for (int s = 0; s < NL + WIN - 1; s++) drive_sample(rnd_sample(), rnd_sample(), 1'b0, 36);
        repeat (100) tick();
        checks++; if (done_cnt !== base) begin fails++; $display("FAIL restart_early_done: got %0d pulses expected 0", done_cnt - base); end
        drive_sample(rnd_sample(), rnd_sample(), 1'b0, 36);
        wait_done(base, 200);
        model_best(el, ep);
        checks++; if (done_cnt - base !== 1) begin fails++; $display("FAIL restart_done_count: got %0d expected 1", done_cnt - base); end
        checks++; if (lag_out !== LW'(el)) begin fails++; $display("FAIL restart_lag_model: got %0d expected %0d", lag_out, el); end
        checks++; if (peak_out !== AW'(ep)) begin fails++; $display("FAIL restart_peak_model: got %0d expected %0d", peak_out, ep); end
    endtask

`ifdef XCORR_SIGN_EN
    task automatic test_sign_square();
        int base;
        int v;
        int ph = 0;
        int el;
        longint ep;
        for (int s = 0; s < 40; s++) begin
            v = ((ph % 64) < 32) ? 8000 : -8000; ph++;
            drive_sample(v, v, 1'b0, 36);
        end
        base = done_cnt;
        pulse_start();
        for (int s = 0; s < WIN + 3; s++) begin
            v = ((ph % 64) < 32) ? 8000 : -8000; ph++;
            drive_sample(v, v, 1'b0, 36);
        end
        wait_done(base, 200);
        model_best(el, ep);
        checks++; if (lag_out !== '0) begin fails++; $display("FAIL sign_lag: got %0d expected 0", lag_out); end
        checks++; if (peak_out !== AW'(WIN)) begin fails++; $display("FAIL sign_peak: got %0d expected %0d", peak_out, WIN); end
        checks++; if (peak_out !== AW'(ep)) begin fails++; $display("FAIL sign_peak_model: got %0d expected %0d", peak_out, ep); end
    endtask
`endif

    initial begin
        test_reset();
        test_impulse();
        test_lead();
        test_overrun();
        test_zero_tie();
        test_reset_restart();
`ifdef XCORR_SIGN_EN
        test_sign_square();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
